addsub_acc: RTL

- Sequential accumulator stage directly downstream of the 4-bit ripple adder/subtractor datapath.
- Accepts one command at a time (add, subtract, load, clear) on a valid/ready handshake and applies it to a registered accumulator.
- Presents the result with carry, signed-overflow and zero flags on a second valid/ready handshake.
- Sits between the operand source and the result consumer in the ALU path.

---
 rtl/addsub_acc_pkg.sv | 14 +
 rtl/addsub_acc_core.sv | 22 ++
 rtl/addsub_acc.sv | 79 +++++++
 3 files changed

// File: rtl/addsub_acc_pkg.sv
// addsub_acc_pkg: command and FSM state encodings shared by the accumulator stage.
package addsub_acc_pkg;
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_e;
endpackage

// File: rtl/addsub_acc_core.sv
// addsub_core: WIDTH-bit ripple add/subtract; k=1 inverts b and injects a carry-in.
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             k,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH:0] c;
    assign c[0] = k;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic bx;
        assign bx       = b[i] ^ k;
        assign sum[i]   = a[i] ^ bx ^ c[i];
        assign c[i + 1] = (a[i] & bx) | (c[i] & (a[i] ^ bx));
    end
    assign cout = c[WIDTH];
    assign ovf  = c[WIDTH] ^ c[WIDTH - 1];
endmodule

// File: rtl/addsub_acc.sv
// addsub_acc: handshaked accumulator applying ADD/SUB/LOAD/CLR, with carry, overflow and zero flags.
module addsub_acc
    import addsub_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] operand_q, acc_q, acc_d, sum, res;
    logic             cout_q, ovf_q, zero_q, cout_d, ovf_d, core_cout, core_ovf, arith;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a   (acc_q),
        .b   (operand_q),
        .k   (op_q == OP_SUB),
        .sum (sum),
        .cout(core_cout),
        .ovf (core_ovf)
    );

    // On overflow the true result has the sign of the old accumulator, so clamp toward it.
    always_comb begin
        arith  = ~op_q[1];
        res    = (SAT && core_ovf) ? {acc_q[WIDTH-1], {(WIDTH-1){~acc_q[WIDTH-1]}}} : sum;
        acc_d  = (op_q == OP_LOAD) ? operand_q : (op_q == OP_CLR) ? '0 : res;
        cout_d = arith & core_cout;
        ovf_d  = arith & core_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_ADD;
            operand_q <= '0;
            acc_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q      <= op_e'(op);
                    operand_q <= operand;
                    state_q   <= EXEC;
                end
                EXEC: begin
                    acc_q   <= acc_d;
                    cout_q  <= cout_d;
                    ovf_q   <= ovf_d;
                    zero_q  <= (acc_d == '0);
                    state_q <= HOLD;
                end
                HOLD: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign acc       = acc_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule
